// File: rtl/lzc_mask_builder.sv
// Rebuilds a bit vector from a stream of (count, empty) beats; last_i closes the vector.
// Define LZC_MASK_BUILDER_THERMO_EN to add the registered thermometer output thermo_o.
module lzc_mask_builder #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [$clog2(WIDTH)-1:0]   cnt_i,
  input  logic                       empty_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           mask_o,
  output logic [$clog2(WIDTH+1)-1:0] pop_o,
  output logic                       dup_o,
  output logic                       err_o
`ifdef LZC_MASK_BUILDER_THERMO_EN
  ,output logic [WIDTH-1:0]          thermo_o
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(WIDTH+1);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "lzc_mask_builder: WIDTH must be >= 2");
  end

  typedef enum logic {ACCUM, HOLD} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_nxt, bit_vec, mask_q;
  logic [PW-1:0]    pop_q, pop_nxt, opop_q;
  logic             dup_q, dup_nxt, err_q, err_nxt, odup_q, oerr_q;
  logic             in_range, set_bit, hit, take, close;
  logic [CW-1:0]    pos;

  // Only a non-power-of-two WIDTH leaves index codes with no matching bit.
  if (WIDTH == (1 << CW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = cnt_i < CW'(WIDTH);
  end

  assign take  = valid_i & ready_o;
  assign close = take & last_i;

  always_comb begin
    pos     = (MODE != 0) ? CW'(WIDTH-1) - cnt_i : cnt_i;
    set_bit = ~empty_i & in_range;
    bit_vec = set_bit ? (WIDTH'(1) << pos) : '0;
    hit     = |(acc_q & bit_vec);
    acc_nxt = acc_q | bit_vec;
    pop_nxt = pop_q + PW'(set_bit & ~hit);
    dup_nxt = dup_q | (set_bit & hit);
    err_nxt = err_q | (~empty_i & ~in_range);
  end

  always_comb begin
    ready_o = (state_q == ACCUM) | ready_i;
    state_d = state_q;
    case (state_q)
      ACCUM: if (close) state_d = HOLD;
      HOLD:  if (!close && ready_i) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  // Accumulator clears on the closing beat so the next vector starts without a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      pop_q <= '0;
      dup_q <= 1'b0;
      err_q <= 1'b0;
    end else if (close) begin
      acc_q <= '0;
      pop_q <= '0;
      dup_q <= 1'b0;
      err_q <= 1'b0;
    end else if (take) begin
      acc_q <= acc_nxt;
      pop_q <= pop_nxt;
      dup_q <= dup_nxt;
      err_q <= err_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      opop_q <= '0;
      odup_q <= 1'b0;
      oerr_q <= 1'b0;
    end else if (close) begin
      mask_q <= acc_nxt;
      opop_q <= pop_nxt;
      odup_q <= dup_nxt;
      oerr_q <= err_nxt;
    end
  end

  assign valid_o = (state_q == HOLD);
  assign mask_o  = mask_q;
  assign pop_o   = opop_q;
  assign dup_o   = odup_q;
  assign err_o   = oerr_q;

`ifdef LZC_MASK_BUILDER_THERMO_EN
  logic [WIDTH-1:0] thermo_nxt, thermo_q;
  logic             run;

  // Running OR from the counting origin toward the far end of the vector.
  always_comb begin
    thermo_nxt = '0;
    run        = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE != 0) begin
        run                    = run | acc_nxt[WIDTH-1-i];
        thermo_nxt[WIDTH-1-i]  = run;
      end else begin
        run           = run | acc_nxt[i];
        thermo_nxt[i] = run;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    thermo_q <= '0;
    else if (close) thermo_q <= thermo_nxt;
  end

  assign thermo_o = thermo_q;
`endif

endmodule
